// File: rtl/cpu_pkg.sv
// Shared encodings for the parameterised CPU controller: FSM states, instruction
// formats, bus-source selects and branch condition codes.
package cpu_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_EXEC = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;

  localparam logic [1:0] FMT_R  = 2'b00;
  localparam logic [1:0] FMT_I  = 2'b01;
  localparam logic [1:0] FMT_BR = 2'b10;
  localparam logic [1:0] FMT_LS = 2'b11;

  localparam logic [3:0] MUX_IMM  = 4'd8;
  localparam logic [3:0] MUX_NONE = 4'd9;
  localparam logic [3:0] MUX_MEM  = 4'd10;

  localparam logic [1:0] COND_AL = 2'b00;
  localparam logic [1:0] COND_Z  = 2'b01;
  localparam logic [1:0] COND_GT = 2'b10;
  localparam logic [1:0] COND_LT = 2'b11;

  function automatic logic [7:0] reg_onehot(input logic [2:0] idx);
    logic [7:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/cpu_ctrl_param_mem_wait_timer.sv
// Counts cycles spent waiting for memory; expired is high during the
// MEM_TIMEOUT-th consecutive enabled cycle.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;

  assign expired = enable && (count == 8'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/cpu_ctrl_param.sv
// Multi-cycle control FSM: captures an instruction on run and sequences
// register, ALU, branch and memory enables as Moore decodes.
module cpu_ctrl_param
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [15:0]       d_inst,
  input  logic              flag_z,
  input  logic              flag_gt,
  input  logic              flag_lt,
  input  logic              mem_ready,
  output logic              en_inst,
  output logic              en_s,
  output logic              en_c,
  output logic [7:0]        en,
  output logic [3:0]        mux_sel,
  output logic [2:0]        sel,
  output logic [DATA_W-1:0] im_d,
  output logic              mem_req,
  output logic              mem_we,
  output logic              pc_load,
  output logic              done,
  output logic              busy,
  output logic              err
);

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [15:0] ir;
  logic        timed_out;
  logic        mem_expired;
  logic        cond_true;

  logic [2:0] rx;
  logic [2:0] ry;
  logic [7:0] imm8;
  logic [2:0] op;
  logic [1:0] cond;
  logic [1:0] fmt;
  logic       is_store;

  assign rx       = ir[15:13];
  assign ry       = ir[12:10];
  assign imm8     = ir[12:5];
  assign op       = ir[4:2];
  assign cond     = ir[3:2];
  assign fmt      = ir[1:0];
  assign is_store = ir[2];

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != S_MEM),
    .enable (state == S_MEM),
    .expired(mem_expired)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (run) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_EXEC;
      S_EXEC:  state_nxt = (fmt == FMT_LS) ? S_MEM : S_WB;
      S_MEM:   if (mem_ready || mem_expired) state_nxt = S_WB;
      S_WB:    state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // timed_out is refreshed every MEM cycle so its last value rides into WB;
  // a ready on the expiry cycle wins over the timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ir        <= '0;
      timed_out <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE) begin
        timed_out <= 1'b0;
        if (run) ir <= d_inst;
      end else if (state == S_MEM) begin
        timed_out <= mem_expired && !mem_ready;
      end
    end
  end

  always_comb begin
    case (cond)
      COND_AL: cond_true = 1'b1;
      COND_Z:  cond_true = flag_z;
      COND_GT: cond_true = flag_gt;
      COND_LT: cond_true = flag_lt;
      default: cond_true = 1'b0;
    endcase
  end

  always_comb begin
    en_inst = 1'b0;
    en_s    = 1'b0;
    en_c    = 1'b0;
    en      = '0;
    mux_sel = MUX_NONE;
    sel     = '0;
    im_d    = '0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    pc_load = 1'b0;
    done    = 1'b0;
    busy    = 1'b0;
    err     = 1'b0;
    case (state)
      S_IDLE: en_inst = 1'b1;
      S_LOAD: begin
        busy = 1'b1;
        if (fmt != FMT_BR) begin
          en_s    = 1'b1;
          mux_sel = {1'b0, rx};
        end
      end
      S_EXEC: begin
        busy = 1'b1;
        case (fmt)
          FMT_R: begin
            mux_sel = {1'b0, ry};
            sel     = op;
            en_c    = 1'b1;
          end
          FMT_I: begin
            mux_sel = MUX_IMM;
            im_d    = DATA_W'(imm8);
            sel     = op;
            en_c    = 1'b1;
          end
          FMT_BR: begin
            pc_load = cond_true;
            im_d    = DATA_W'(ir[15:4]);
          end
          default: begin
            mux_sel = {1'b0, ry};
            mem_req = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        mem_we  = is_store;
        mux_sel = is_store ? {1'b0, rx} : {1'b0, ry};
      end
      S_WB: begin
        busy = 1'b1;
        done = 1'b1;
        err  = timed_out;
        if (fmt == FMT_R || fmt == FMT_I) begin
          en = reg_onehot(rx);
        end else if (fmt == FMT_LS && !is_store && !timed_out) begin
          en      = reg_onehot(rx);
          mux_sel = MUX_MEM;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_param.sv
// Scoreboard bench for cpu_ctrl_param: the stimulus queues the expected output
// vector for each cycle it drives, and a negedge monitor pops and compares.
module tb_cpu_ctrl_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [15:0] d_inst;
  logic        flag_z, flag_gt, flag_lt;
  logic        mem_ready;
  logic        en_inst, en_s, en_c;
  logic [7:0]  en;
  logic [3:0]  mux_sel;
  logic [2:0]  sel;
  logic [15:0] im_d;
  logic        mem_req, mem_we, pc_load, done, busy, err;

  always #5 clk = ~clk;

  cpu_ctrl_param #(
    .DATA_W     (16),
    .MEM_TIMEOUT(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .d_inst   (d_inst),
    .flag_z   (flag_z),
    .flag_gt  (flag_gt),
    .flag_lt  (flag_lt),
    .mem_ready(mem_ready),
    .en_inst  (en_inst),
    .en_s     (en_s),
    .en_c     (en_c),
    .en       (en),
    .mux_sel  (mux_sel),
    .sel      (sel),
    .im_d     (im_d),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .pc_load  (pc_load),
    .done     (done),
    .busy     (busy),
    .err      (err)
  );

  typedef struct packed {
    logic        en_inst;
    logic        en_s;
    logic        en_c;
    logic [7:0]  en;
    logic [3:0]  mux_sel;
    logic [2:0]  sel;
    logic [15:0] im_d;
    logic        mem_req;
    logic        mem_we;
    logic        pc_load;
    logic        done;
    logic        busy;
    logic        err;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  exp_t  mon_e, mon_a;
  string mon_t;

  function automatic string show(input exp_t x);
    return $sformatf("inst=%b s=%b c=%b en=%h mux=%0d sel=%0d imd=%h req=%b we=%b pc=%b done=%b busy=%b err=%b",
                     x.en_inst, x.en_s, x.en_c, x.en, x.mux_sel, x.sel, x.im_d,
                     x.mem_req, x.mem_we, x.pc_load, x.done, x.busy, x.err);
  endfunction

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      mon_t = tag_q.pop_front();
      mon_a = {en_inst, en_s, en_c, en, mux_sel, sel, im_d,
               mem_req, mem_we, pc_load, done, busy, err};
      checks++;
      if (mon_a !== mon_e) begin
        errors++;
        $display("FAIL %s: got [%s] expected [%s]", mon_t, show(mon_a), show(mon_e));
      end
    end
  end

  function automatic exp_t e_idle();
    exp_t x = '0;
    x.mux_sel = 4'd9;
    x.en_inst = 1'b1;
    return x;
  endfunction

  function automatic exp_t e_busy();
    exp_t x = '0;
    x.mux_sel = 4'd9;
    x.busy    = 1'b1;
    return x;
  endfunction

  function automatic exp_t e_load(input logic [3:0] m);
    exp_t x = e_busy();
    x.en_s = 1'b1;
    x.mux_sel = m;
    return x;
  endfunction

  function automatic exp_t e_alu(input logic [3:0] m, input logic [2:0] s, input logic [15:0] i);
    exp_t x = e_busy();
    x.mux_sel = m;
    x.sel = s;
    x.im_d = i;
    x.en_c = 1'b1;
    return x;
  endfunction

  function automatic exp_t e_br(input logic pc, input logic [15:0] i);
    exp_t x = e_busy();
    x.pc_load = pc;
    x.im_d = i;
    return x;
  endfunction

  function automatic exp_t e_mem(input logic [3:0] m, input logic we);
    exp_t x = e_busy();
    x.mux_sel = m;
    x.mem_req = 1'b1;
    x.mem_we = we;
    return x;
  endfunction

  function automatic exp_t e_wb(input logic [7:0] w, input logic [3:0] m, input logic er);
    exp_t x = e_busy();
    x.en = w;
    x.mux_sel = m;
    x.done = 1'b1;
    x.err = er;
    return x;
  endfunction

  task automatic cyc(input string t, input exp_t e);
    sb_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  // Load of r3 from [r6] (0x7803) with mem_ready never asserted: 4 MEM cycles then err.
  task automatic timeout_load(input string t);
    run = 1'b1; d_inst = 16'h7803; mem_ready = 1'b0;
    cyc({t, "_idle"}, e_idle());
    run = 1'b0;
    cyc({t, "_load"}, e_load(4'd3));
    cyc({t, "_exec"}, e_mem(4'd6, 1'b0));
    for (int i = 0; i < 4; i++) cyc($sformatf("%s_mem%0d", t, i), e_mem(4'd6, 1'b0));
    cyc({t, "_wb"}, e_wb(8'h00, 4'd9, 1'b1));
    cyc({t, "_back"}, e_idle());
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got time limit expired, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; run = 1'b1; d_inst = 16'h540C;
    flag_z = 1'b0; flag_gt = 1'b0; flag_lt = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    cyc("reset_hold", e_idle());
    reset = 1'b0; run = 1'b0;
    cyc("reset_over_run", e_idle());

    // R-format rx=2 ry=5 op=3; d_inst, run and mem_ready toggled while busy
    run = 1'b1; d_inst = 16'h540C;
    cyc("r_idle", e_idle());
    d_inst = 16'hFFFF; mem_ready = 1'b1;
    cyc("r_load", e_load(4'd2));
    cyc("r_exec", e_alu(4'd5, 3'd3, 16'h0000));
    cyc("r_wb", e_wb(8'h04, 4'd9, 1'b0));
    run = 1'b0; mem_ready = 1'b0;
    cyc("r_back", e_idle());

    // I-format rx=7 imm8=A5 op=1
    run = 1'b1; d_inst = 16'hF4A5;
    cyc("i_idle", e_idle());
    run = 1'b0; d_inst = 16'h0000;
    cyc("i_load", e_load(4'd7));
    cyc("i_exec", e_alu(4'd8, 3'd1, 16'h00A5));
    cyc("i_wb", e_wb(8'h80, 4'd9, 1'b0));

    // Branch cond=Z, taken
    run = 1'b1; d_inst = 16'hABC6;
    cyc("brz1_idle", e_idle());
    run = 1'b0;
    cyc("brz1_load", e_busy());
    flag_z = 1'b1;
    cyc("brz1_exec", e_br(1'b1, 16'h0ABC));
    flag_z = 1'b0;
    cyc("brz1_wb", e_wb(8'h00, 4'd9, 1'b0));

    // Branch cond=Z, not taken although GT/LT are set
    run = 1'b1;
    cyc("brz0_idle", e_idle());
    run = 1'b0;
    cyc("brz0_load", e_busy());
    flag_gt = 1'b1; flag_lt = 1'b1;
    cyc("brz0_exec", e_br(1'b0, 16'h0ABC));
    flag_gt = 1'b0; flag_lt = 1'b0;
    cyc("brz0_wb", e_wb(8'h00, 4'd9, 1'b0));

    // Branch cond=GT, taken
    run = 1'b1; d_inst = 16'hABCA;
    cyc("brgt_idle", e_idle());
    run = 1'b0;
    cyc("brgt_load", e_busy());
    flag_gt = 1'b1;
    cyc("brgt_exec", e_br(1'b1, 16'h0ABC));
    flag_gt = 1'b0;
    cyc("brgt_wb", e_wb(8'h00, 4'd9, 1'b0));

    // Load r3 <- [r6], ready on third MEM cycle
    run = 1'b1; d_inst = 16'h7803;
    cyc("ld_idle", e_idle());
    run = 1'b0;
    cyc("ld_load", e_load(4'd3));
    cyc("ld_exec", e_mem(4'd6, 1'b0));
    cyc("ld_mem0", e_mem(4'd6, 1'b0));
    cyc("ld_mem1", e_mem(4'd6, 1'b0));
    mem_ready = 1'b1;
    cyc("ld_mem2", e_mem(4'd6, 1'b0));
    mem_ready = 1'b0;
    cyc("ld_wb", e_wb(8'h08, 4'd10, 1'b0));

    timeout_load("to");

    // Ready on the very cycle the timer expires counts as success
    run = 1'b1; d_inst = 16'h7803;
    cyc("edge_idle", e_idle());
    run = 1'b0;
    cyc("edge_load", e_load(4'd3));
    cyc("edge_exec", e_mem(4'd6, 1'b0));
    for (int i = 0; i < 3; i++) cyc($sformatf("edge_mem%0d", i), e_mem(4'd6, 1'b0));
    mem_ready = 1'b1;
    cyc("edge_mem3", e_mem(4'd6, 1'b0));
    mem_ready = 1'b0;
    cyc("edge_wb", e_wb(8'h08, 4'd10, 1'b0));

    // Store [r4] <- r1, ready on first MEM cycle
    run = 1'b1; d_inst = 16'h3007;
    cyc("st_idle", e_idle());
    run = 1'b0;
    cyc("st_load", e_load(4'd1));
    cyc("st_exec", e_mem(4'd4, 1'b0));
    mem_ready = 1'b1;
    cyc("st_mem", e_mem(4'd1, 1'b1));
    mem_ready = 1'b0;
    cyc("st_wb", e_wb(8'h00, 4'd9, 1'b0));

    // Reset during MEM aborts with no done/err
    run = 1'b1; d_inst = 16'h7803;
    cyc("rst_idle", e_idle());
    run = 1'b0;
    cyc("rst_load", e_load(4'd3));
    cyc("rst_exec", e_mem(4'd6, 1'b0));
    cyc("rst_mem0", e_mem(4'd6, 1'b0));
    reset = 1'b1;
    cyc("rst_mem1", e_mem(4'd6, 1'b0));
    reset = 1'b0; mem_ready = 1'b1;
    cyc("rst_after", e_idle());
    mem_ready = 1'b0;

    // Normal R-format after the abort: rx=0 ry=1 op=7
    run = 1'b1; d_inst = 16'h041C;
    cyc("post_idle", e_idle());
    run = 1'b0;
    cyc("post_load", e_load(4'd0));
    cyc("post_exec", e_alu(4'd1, 3'd7, 16'h0000));
    cyc("post_wb", e_wb(8'h01, 4'd9, 1'b0));

    timeout_load("post_to");

    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expectations, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl_param.md
CPU_CTRL_PARAM -- requirements
Module: cpu_ctrl_param

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, setting the width of the immediate/data path (min 16).
REQ-002 The block SHALL have parameter MEM_TIMEOUT, default 15, setting the maximum cycles spent waiting on mem_ready (range 1..255).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 run  input  1  start request; sampled only in S_IDLE.
REQ-006 d_inst  input  16  instruction word; [15:13] rx, [12:10] ry, [12:5] imm8, [4:2] alu op / ls mode, [3:2] branch cond, [1:0] format.
REQ-007 flag_z, flag_gt, flag_lt  input  1 each  ALU compare flags, valid in S_EXEC.
REQ-008 mem_ready  input  1  memory completion strobe.
REQ-009 en_inst  output  1  instruction-register load enable.
REQ-010 en_s  output  1  source latch enable.
REQ-011 en_c  output  1  ALU result latch enable.
REQ-012 en  output  8  one-hot register write enable.
REQ-013 mux_sel  output  4  bus source (0-7 regs, 8 imm, 9 none, 10 mem data).
REQ-014 sel  output  3  ALU op.
REQ-015 im_d  output  DATA_W  immediate / branch target.
REQ-016 mem_req, mem_we  output  1 each  memory request, write qualifier.
REQ-017 pc_load  output  1  branch-taken strobe.
REQ-018 done, busy, err  output  1 each  completion pulse, in-flight flag, timeout pulse.

Function
REQ-019 On run=1 in S_IDLE, the block SHALL capture d_inst into an internal register; all decoding SHALL use the captured copy, so d_inst may change afterwards.
REQ-020 The FSM SHALL have states S_IDLE, S_LOAD, S_EXEC, S_MEM, S_WB with transitions IDLE->LOAD on run, LOAD->EXEC, EXEC->MEM if format 11 else EXEC->WB, MEM->WB on mem_ready or timeout, WB->IDLE.
REQ-021 Outputs SHALL be Moore decodes of state and captured instruction; default values: mux_sel=9, everything else 0.
REQ-022 In S_IDLE: en_inst=1, busy=0.
REQ-023 In S_LOAD: for formats 00/01/11, en_s=1 and mux_sel=rx; for format 10, no enables.
REQ-024 In S_EXEC, format 00: mux_sel=ry, sel=[4:2], en_c=1.
REQ-025 In S_EXEC, format 01: mux_sel=8, im_d=zero-extended imm8, sel=[4:2], en_c=1.
REQ-026 In S_EXEC, format 10: pc_load=1 iff the condition holds (00 always, 01 flag_z, 10 flag_gt, 11 flag_lt); im_d=zero-extended [15:4].
REQ-027 In S_EXEC, format 11: mux_sel=ry (address) and mem_req=1.
REQ-028 In S_MEM: mem_req=1, mem_we=[2], mux_sel=ry (load) or rx (store).
REQ-029 In S_MEM, a wait counter SHALL count cycles; if it reaches MEM_TIMEOUT without mem_ready, the FSM SHALL go to S_WB with err=1 for one cycle and suppress writeback.
REQ-030 In S_WB: done=1 for one cycle. Formats 00/01 SHALL set en[rx]=1. A format-11 load SHALL set en[rx]=1 and mux_sel=10, unless timed out. Stores and branches SHALL set en=0.
REQ-031 busy SHALL be 1 in every state except S_IDLE, and en_inst SHALL be 0 in every state except S_IDLE.
REQ-032 run outside S_IDLE SHALL be ignored.
REQ-033 A mem_ready outside S_MEM SHALL be ignored.
REQ-034 mem_ready arriving on the same cycle the counter hits MEM_TIMEOUT SHALL count as success (no err).
REQ-035 Latency SHALL be exactly 3 cycles run-to-done for formats 00/01/10, and 4+wait cycles for format 11.

Reset
REQ-036 reset=1 at a clock edge SHALL force S_IDLE, clear the captured instruction and wait counter, and drive all outputs to defaults, including mid-operation; no done or err SHALL be issued for the aborted instruction.
REQ-037 reset SHALL take priority over run.

Structure
REQ-038 A shared package cpu_pkg SHALL hold the state encoding, format codes (FMT_R, FMT_I, FMT_BR, FMT_LS), the MUX_IMM=8 / MUX_NONE=9 / MUX_MEM=10 constants, and the branch condition codes.
REQ-039 The memory wait counter SHALL be a sub-module mem_wait_timer (clear, enable, MEM_TIMEOUT parameter, expired output); everything else SHALL stay in one module.

Verification
REQ-040 Format 00, rx=2, ry=5, op=3, run pulse: LOAD mux_sel=2 en_s; EXEC mux_sel=5 sel=3 en_c; WB en=8'h04 done; 3 cycles.
REQ-041 Format 01, imm8=8'hA5, rx=7: EXEC im_d=16'h00A5 mux_sel=8; WB en=8'h80.
REQ-042 Format 10, cond=01, flag_z=1, then flag_z=0: pc_load=1 with im_d=[15:4] in the first case, pc_load=0 in the second; en=0 in WB for both.
REQ-043 Format 11 load, mem_ready after 3 cycles: mem_req=1 for 4 cycles, WB mux_sel=10 en[rx]=1, err=0.
REQ-044 Format 11 with mem_ready never asserted, MEM_TIMEOUT=4: err=1 for one cycle, en=0, done=1, return to S_IDLE.
REQ-045 reset asserted in S_MEM: next cycle S_IDLE, mem_req=0, busy=0, no done; a following run is accepted normally.
